// File: rtl/axis_arb_mux_rr.sv
// Packet-level N:1 AXI-stream mux: round-robin arbiter with ack-blocking grant hold,
// registered output stage with one-entry skid buffer.
module axis_arb_mux_rr #(
  parameter int PORTS                 = 4,
  parameter int DATA_W                = 32,
  parameter int USER_W                = 1,
  parameter int ARB_ROUND_ROBIN       = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 1,
  localparam int IDW                  = (PORTS > 2) ? $clog2(PORTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         s_valid_i,
  output logic [PORTS-1:0]         s_ready_o,
  input  logic [PORTS*DATA_W-1:0]  s_data_i,
  input  logic [PORTS*USER_W-1:0]  s_user_i,
  input  logic [PORTS-1:0]         s_last_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [DATA_W-1:0]        m_data_o,
  output logic [USER_W-1:0]        m_user_o,
  output logic                     m_last_o,
  output logic [IDW-1:0]           m_id_o
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [USER_W-1:0] user;
    logic              last;
    logic [IDW-1:0]    id;
  } beat_t;

  logic [PORTS-1:0] gnt_q, gnt_d, mask_q, mask_d, req, req_m, pick;
  logic [IDW-1:0]   enc_q, enc_d;
  logic             gnt_valid_q, ack, found;
  logic             int_ready_q, int_ready_d, int_valid;
  logic             m_valid_q, m_valid_d, skid_valid_q, skid_valid_d;
  logic             ld_out, ld_skid, skid_to_out;
  beat_t            in_beat, out_q, skid_q;

  assign s_ready_o = gnt_q & {PORTS{gnt_valid_q & int_ready_q}};
  // The finishing port drops out of the request at its release edge so others win next.
  assign req       = s_valid_i & ~(gnt_q & s_ready_o & s_last_i);
  assign ack       = |(gnt_q & s_valid_i & s_ready_o & s_last_i);
  assign int_valid = |(s_valid_i & s_ready_o);

  always_comb begin
    req_m = req & mask_q;
    pick  = (ARB_ROUND_ROBIN != 0 && |req_m) ? req_m : req;
    gnt_d = '0;
    enc_d = '0;
    found = 1'b0;
    if (ARB_LSB_HIGH_PRIORITY != 0) begin
      for (int i = 0; i < PORTS; i++)
        if (pick[i] && !found) begin
          found    = 1'b1;
          gnt_d[i] = 1'b1;
          enc_d    = IDW'(i);
        end
    end else begin
      for (int i = PORTS-1; i >= 0; i--)
        if (pick[i] && !found) begin
          found    = 1'b1;
          gnt_d[i] = 1'b1;
          enc_d    = IDW'(i);
        end
    end
    mask_d = '0;
    for (int i = 0; i < PORTS; i++)
      mask_d[i] = (ARB_LSB_HIGH_PRIORITY != 0) ? (i > int'(enc_d)) : (i < int'(enc_d));
  end

  always_comb begin
    in_beat    = '0;
    in_beat.id = enc_q;
    for (int i = 0; i < PORTS; i++)
      if (i == int'(enc_q)) begin
        in_beat.data = s_data_i[i*DATA_W +: DATA_W];
        in_beat.user = s_user_i[i*USER_W +: USER_W];
        in_beat.last = s_last_i[i];
      end
  end

  // Skid holds the beat accepted while the output was stalled; it drains before new input.
  always_comb begin
    m_valid_d    = m_valid_q;
    skid_valid_d = skid_valid_q;
    ld_out       = 1'b0;
    ld_skid      = 1'b0;
    skid_to_out  = 1'b0;
    if (int_ready_q) begin
      if (m_ready_i || !m_valid_q) begin
        m_valid_d = int_valid;
        ld_out    = int_valid;
      end else begin
        skid_valid_d = int_valid;
        ld_skid      = int_valid;
      end
    end else if (m_ready_i) begin
      m_valid_d    = skid_valid_q;
      skid_valid_d = 1'b0;
      skid_to_out  = skid_valid_q;
    end
    int_ready_d = m_ready_i || (!skid_valid_q && (!m_valid_q || !int_valid));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q        <= '0;
      gnt_valid_q  <= 1'b0;
      enc_q        <= '0;
      mask_q       <= '0;
      int_ready_q  <= 1'b0;
      m_valid_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      if (!gnt_valid_q || ack) begin
        gnt_q       <= gnt_d;
        gnt_valid_q <= |req;
        enc_q       <= enc_d;
        if (|req) mask_q <= mask_d;
      end
      int_ready_q  <= int_ready_d;
      m_valid_q    <= m_valid_d;
      skid_valid_q <= skid_valid_d;
      if (ld_out) out_q <= in_beat;
      else if (skid_to_out) out_q <= skid_q;
      if (ld_skid) skid_q <= in_beat;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = out_q.data;
  assign m_user_o  = out_q.user;
  assign m_last_o  = out_q.last;
  assign m_id_o    = out_q.id;

endmodule

// File: tb/tb_axis_arb_mux_rr.sv
// Bench for axis_arb_mux_rr: per-port beat queues drive the inputs, a FIFO of accepted
// beats predicts the output stream, directed scenarios check ordering and latency.
module tb_axis_arb_mux_rr;
  localparam int PORTS = 4, DATA_W = 32, USER_W = 1, IDW = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic [PORTS-1:0]        s_valid, s_ready, s_last;
  logic [PORTS*DATA_W-1:0] s_data;
  logic [PORTS*USER_W-1:0] s_user;
  logic                    m_valid, m_ready, m_last;
  logic [DATA_W-1:0]       m_data;
  logic [USER_W-1:0]       m_user;
  logic [IDW-1:0]          m_id;

  axis_arb_mux_rr #(.PORTS(PORTS), .DATA_W(DATA_W), .USER_W(USER_W),
                    .ARB_ROUND_ROBIN(1), .ARB_LSB_HIGH_PRIORITY(1)) dut (
    .clk(clk), .rst(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_user_i(s_user),
    .s_last_i(s_last), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
    .m_user_o(m_user), .m_last_o(m_last), .m_id_o(m_id)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic user; logic last; } beat_t;
  typedef struct { int port; logic [31:0] data; logic user; logic last; int cyc; } obs_t;

  beat_t pq[PORTS][$];
  obs_t  acc_q[$];
  obs_t  out_log[$];
  int    checks = 0, errors = 0;
  int    cyc, open_port, mr_mode;
  int    first_rdy[PORTS];
  bit    pres[PORTS];
  bit    rand_mode;
  logic [PORTS-1:0] acc_now;
  logic        prev_stall, prev_last, prev_user;
  logic [31:0] prev_data;
  logic [1:0]  prev_id;

  function automatic void push_beat(int p, logic [31:0] d, logic lst, logic usr);
    beat_t b;
    b.data = d; b.last = lst; b.user = usr;
    pq[p].push_back(b);
  endfunction

  function automatic void push_pkt(int p, int len, logic [31:0] base, logic usr);
    for (int i = 0; i < len; i++) push_beat(p, base + 32'(i), i == len-1, usr);
  endfunction

  function automatic bit idle();
    for (int p = 0; p < PORTS; p++) if (pq[p].size() != 0 || pres[p]) return 1'b0;
    return acc_q.size() == 0;
  endfunction

  task automatic clr_tb();
    for (int p = 0; p < PORTS; p++) begin
      pq[p].delete(); pres[p] = 1'b0; first_rdy[p] = -1;
    end
    acc_q.delete(); out_log.delete();
    acc_now = '0; open_port = -1; prev_stall = 1'b0; cyc = 0;
    rand_mode = 1'b0; mr_mode = 0;
    s_valid = '0; s_data = '0; s_user = '0; s_last = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; m_ready = 1'b1;
    s_valid = '0; s_data = '0; s_user = '0; s_last = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr_tb();
  endtask

  // One cycle: update queues, drive inputs at negedge, sample and score just after.
  task automatic step();
    beat_t b;
    obs_t  o, e;
    @(negedge clk);
    for (int p = 0; p < PORTS; p++)
      if (acc_now[p]) begin
        void'(pq[p].pop_front());
        pres[p] = 1'b0;
      end
    acc_now = '0;
    s_valid = '0; s_data = '0; s_user = '0; s_last = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (!pres[p] && pq[p].size() > 0 && (!rand_mode || $urandom_range(3) != 0)) pres[p] = 1'b1;
      if (pres[p]) begin
        b = pq[p][0];
        s_valid[p] = 1'b1;
        s_data[p*DATA_W +: DATA_W] = b.data;
        s_user[p] = b.user;
        s_last[p] = b.last;
      end
    end
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 2) == 0;
      default: m_ready = 1'($urandom_range(1));
    endcase
    #1;
    checks++;
    if ($countones(s_ready) > 1) begin
      errors++; $display("FAIL ready_onehot: s_ready=%b, want at most one bit", s_ready);
    end
    for (int p = 0; p < PORTS; p++) begin
      if (s_ready[p] && first_rdy[p] < 0) first_rdy[p] = cyc;
      if (s_valid[p] && s_ready[p]) begin
        acc_now[p] = 1'b1;
        checks++;
        if (open_port >= 0 && open_port != p) begin
          errors++; $display("FAIL atomic_in: accepted port %0d, want port %0d", p, open_port);
        end
        o.port = p; o.data = pq[p][0].data; o.user = pq[p][0].user; o.last = pq[p][0].last; o.cyc = cyc;
        acc_q.push_back(o);
        open_port = o.last ? -1 : p;
      end
    end
    if (prev_stall) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last ||
          m_user[0] !== prev_user || m_id !== prev_id) begin
        errors++;
        $display("FAIL stall_stable: got v=%b d=%h l=%b id=%0d, want v=1 d=%h l=%b id=%0d",
                 m_valid, m_data, m_last, m_id, prev_data, prev_last, prev_id);
      end
    end
    if (m_valid && m_ready) begin
      checks++;
      if (acc_q.size() == 0) begin
        errors++; $display("FAIL sb_extra: got d=%h id=%0d, want no beat", m_data, m_id);
      end else begin
        e = acc_q.pop_front();
        if (m_data !== e.data || m_last !== e.last || m_user[0] !== e.user || int'(m_id) != e.port) begin
          errors++;
          $display("FAIL sb_beat: got id=%0d d=%h l=%b u=%b, want id=%0d d=%h l=%b u=%b",
                   m_id, m_data, m_last, m_user, e.port, e.data, e.last, e.user);
        end
      end
      o.port = int'(m_id); o.data = m_data; o.user = m_user[0]; o.last = m_last; o.cyc = cyc;
      out_log.push_back(o);
    end
    prev_stall = m_valid & ~m_ready;
    prev_data = m_data; prev_last = m_last; prev_user = m_user[0]; prev_id = m_id;
    cyc++;
  endtask

  task automatic run_idle(input int maxc, input string name);
    for (int k = 0; k < maxc; k++) begin
      step();
      if (idle()) break;
    end
    checks++;
    if (!idle()) begin
      errors++; $display("FAIL %s_timeout: still busy after %0d cycles, want drained", name, maxc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b0;
    s_valid = '1; s_last = '1; s_data = '1; s_user = '1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== '0) begin
      errors++; $display("FAIL reset_valid: m_valid=%b s_ready=%b, want 0 and 0000", m_valid, s_ready);
    end
    checks++;
    if (m_data !== '0 || m_user !== '0 || m_last !== 1'b0 || m_id !== '0) begin
      errors++; $display("FAIL reset_data: d=%h u=%b l=%b id=%0d, want all zero", m_data, m_user, m_last, m_id);
    end
  endtask

  task automatic test_single_port();
    logic [31:0] exp_d[3];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
    do_reset();
    push_beat(0, 32'h11, 1'b0, 1'b0);
    push_beat(0, 32'h22, 1'b0, 1'b1);
    push_beat(0, 32'h33, 1'b1, 1'b0);
    run_idle(30, "t1");
    checks++;
    if (first_rdy[0] != 1) begin
      errors++; $display("FAIL t1_ready_lat: s_ready cycle %0d, want 1", first_rdy[0]);
    end
    checks++;
    if (out_log.size() != 3) begin
      errors++; $display("FAIL t1_count: %0d beats, want 3", out_log.size());
    end else begin
      checks++;
      if (out_log[0].cyc != 2) begin
        errors++; $display("FAIL t1_out_lat: first beat cycle %0d, want 2", out_log[0].cyc);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (out_log[i].data !== exp_d[i] || out_log[i].port != 0 || out_log[i].last !== (i == 2)) begin
          errors++;
          $display("FAIL t1_beat%0d: d=%h id=%0d l=%b, want d=%h id=0 l=%b",
                   i, out_log[i].data, out_log[i].port, out_log[i].last, exp_d[i], i == 2);
        end
      end
    end
  endtask

  task automatic test_contention();
    logic [31:0] exp_d[4];
    int          exp_id[4];
    exp_d[0] = 32'hA1; exp_d[1] = 32'hA2; exp_d[2] = 32'hB1; exp_d[3] = 32'hB2;
    exp_id[0] = 1; exp_id[1] = 1; exp_id[2] = 2; exp_id[3] = 2;
    do_reset();
    push_beat(1, 32'hA1, 1'b0, 1'b0); push_beat(1, 32'hA2, 1'b1, 1'b0);
    push_beat(2, 32'hB1, 1'b0, 1'b1); push_beat(2, 32'hB2, 1'b1, 1'b1);
    run_idle(30, "t2");
    checks++;
    if (out_log.size() != 4) begin
      errors++; $display("FAIL t2_count: %0d beats, want 4", out_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_log[i].data !== exp_d[i] || out_log[i].port != exp_id[i]) begin
          errors++; $display("FAIL t2_beat%0d: d=%h id=%0d, want d=%h id=%0d",
                             i, out_log[i].data, out_log[i].port, exp_d[i], exp_id[i]);
        end
      end
      checks++;
      if (out_log[3].cyc - out_log[0].cyc != 3) begin
        errors++; $display("FAIL t2_bubble: span %0d cycles, want 3", out_log[3].cyc - out_log[0].cyc);
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int p = 0; p < PORTS; p++)
      for (int k = 0; k < 3; k++) push_pkt(p, 1, 32'((p << 8) | k), 1'b0);
    run_idle(60, "t3");
    checks++;
    if (out_log.size() != 12) begin
      errors++; $display("FAIL t3_count: %0d beats, want 12", out_log.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (out_log[i].port != i % 4 || out_log[i].cyc != out_log[0].cyc + i) begin
          errors++; $display("FAIL t3_rr%0d: id=%0d cyc=%0d, want id=%0d cyc=%0d",
                             i, out_log[i].port, out_log[i].cyc, i % 4, out_log[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mr_mode = 1;
    push_pkt(0, 4, 32'hA0, 1'b1);
    run_idle(40, "t4");
    checks++;
    if (out_log.size() != 4) begin
      errors++; $display("FAIL t4_count: %0d beats, want 4", out_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_log[i].data !== 32'hA0 + 32'(i) || out_log[i].last !== (i == 3)) begin
          errors++; $display("FAIL t4_beat%0d: d=%h l=%b, want d=%h l=%b",
                             i, out_log[i].data, out_log[i].last, 32'hA0 + 32'(i), i == 3);
        end
      end
    end
  endtask

  task automatic test_release();
    int exp_id[4];
    exp_id[0] = 0; exp_id[1] = 0; exp_id[2] = 3; exp_id[3] = 0;
    do_reset();
    push_pkt(0, 2, 32'h50, 1'b0);
    push_pkt(0, 1, 32'h60, 1'b0);
    step();
    push_pkt(3, 1, 32'h70, 1'b1);
    run_idle(40, "t5");
    checks++;
    if (out_log.size() != 4) begin
      errors++; $display("FAIL t5_count: %0d beats, want 4", out_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_log[i].port != exp_id[i]) begin
          errors++; $display("FAIL t5_order%0d: id=%0d d=%h, want id=%0d",
                             i, out_log[i].port, out_log[i].data, exp_id[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int nlast;
    do_reset();
    push_pkt(0, 4, 32'hC0, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== '0) begin
      errors++; $display("FAIL t6_reset: m_valid=%b s_ready=%b, want 0 and 0000", m_valid, s_ready);
    end
    nlast = 0;
    foreach (out_log[i]) if (out_log[i].last) nlast++;
    checks++;
    if (nlast != 0) begin
      errors++; $display("FAIL t6_trunc: %0d last beats before reset, want 0", nlast);
    end
    rst = 1'b0;
    clr_tb();
    push_pkt(1, 1, 32'hD0, 1'b1);
    run_idle(20, "t6");
    checks++;
    if (out_log.size() != 1 || out_log[0].cyc != 2 || out_log[0].port != 1 || out_log[0].data !== 32'hD0) begin
      errors++;
      $display("FAIL t6_after: beats=%0d cyc=%0d id=%0d d=%h, want 1 beat cyc=2 id=1 d=d0",
               out_log.size(), out_log.size() ? out_log[0].cyc : -1,
               out_log.size() ? out_log[0].port : -1, out_log.size() ? out_log[0].data : 32'h0);
    end
  endtask

  task automatic test_random();
    int total;
    do_reset();
    rand_mode = 1'b1;
    mr_mode = 2;
    total = 0;
    for (int p = 0; p < PORTS; p++)
      for (int k = 0; k < 8; k++) begin
        int len;
        len = $urandom_range(4, 1);
        total += len;
        push_pkt(p, len, 32'((p << 24) | (k << 16)), 1'($urandom_range(1)));
      end
    run_idle(4000, "rand");
    checks++;
    if (out_log.size() != total) begin
      errors++; $display("FAIL rand_count: %0d beats, want %0d", out_log.size(), total);
    end
  endtask

  initial begin
    s_valid = '0; s_data = '0; s_user = '0; s_last = '0; m_ready = 1'b0;
    test_reset();
    test_single_port();
    test_contention();
    test_fairness();
    test_backpressure();
    test_release();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
